afu_rd_issue: RTL and testbench
===============================

# afu_rd_issue

Read-request issue and response reorder stage feeding the C0 read path of `afu_top`. It accepts cache-line read requests from the SMEM pipeline and issues them as CCI-P C0 memory read headers, throttled by `spl_tx_rd_almostfull` and by a credit limit. Each request occupies a slot in a `MAX_OUTSTANDING`-entry ring buffer. Returned lines are written back by slot index and delivered to the pipeline in request order with the caller's tag. Ordering is therefore correct even when the upstream interface does not sort responses.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 64: ring slots, which is also the maximum number of issued-but-undelivered reads. Must be a power of two, from 2 to 256.
- `TAG_W`, default 16: width of the caller tag carried through with each request.

Ports:
- `CLK_400M`  in  1  sole clock.
- `spl_reset_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  pipeline read request is valid.
- `req_ready`  out  1  block accepts a request this cycle.
- `req_addr`  in  42  cache-line address.
- `req_tag`  in  `TAG_W`  caller tag, returned with the data.
- `spl_tx_rd_almostfull`  in  1  C0 TX almost-full.
- `afu_tx_rd_valid`  out  1  C0 read request valid.
- `afu_tx_rd_hdr`  out  `t_ccip_c0_ReqMemHdr`  C0 read header.
- `spl_rx_rd_valid`  in  1  C0 read response valid.
- `spl_rx_rd_hdr`  in  `t_ccip_c0_RspMemHdr`  C0 response header.
- `spl_rx_data`  in  512  response line.
- `rsp_valid`  out  1  ordered response is valid.
- `rsp_ready`  in  1  pipeline consumes the ordered response.
- `rsp_tag`  out  `TAG_W`  tag of the delivered response.
- `rsp_data`  out  512  data of the delivered response.
- `outstanding`  out  log2(`MAX_OUTSTANDING`)+1  occupied slots.
- `err_unexpected_rsp`  out  1  sticky: a response arrived for a slot that was not pending.

## Operation
- State:
  - `wr_ptr` (issue) and `rd_ptr` (delivery), each log2(`MAX_OUTSTANDING`)+1 bits including a wrap bit.
  - Per-slot `pending` and `filled` bits.
  - Tag array and 512-bit data array.
- Occupancy: `outstanding` = `wr_ptr` − `rd_ptr` (modular). The ring is full when `outstanding` = `MAX_OUTSTANDING`.
- Ready: `req_ready` = !`spl_tx_rd_almostfull` && !full. It is combinational from registered state and the almost-full input, and is independent of `req_valid`.
- Issue, on a cycle where `req_valid` && `req_ready`:
  - Store `req_tag` at slot `wr_ptr`; set `pending`; increment `wr_ptr`.
  - Register the header for the next cycle: address = `req_addr`, `mdata[7:0]` = slot index (upper mdata bits 0), `req_type` = `eREQ_RDLINE_I`, `vc_sel` = `eVC_VA`, `cl_len` = `eCL_LEN_1`.
- Response:
  - `spl_rx_rd_valid`, `spl_rx_rd_hdr` and `spl_rx_data` are registered for one cycle.
  - Slot = `mdata` masked to log2(`MAX_OUTSTANDING`) bits.
  - If the slot is `pending` && !`filled`: write the data and set `filled`.
  - Otherwise: drop the data and set `err_unexpected_rsp`, which stays set until reset.
- Delivery:
  - When slot `rd_ptr` is `filled`, present its tag and data on registered outputs with `rsp_valid` = 1.
  - On `rsp_valid` && `rsp_ready`: clear `pending` and `filled`, increment `rd_ptr`, and load the next slot if it is `filled`.
  - Back-to-back delivery at one response per cycle must be sustained.
- Backpressure safety: CCI-P responses cannot be stalled. The credit rule (at most `MAX_OUTSTANDING` slots occupied) guarantees every response has a slot.
- Simultaneous issue and delivery in one cycle: `outstanding` is unchanged.
- Simultaneous response write to slot `rd_ptr` and delivery of slot `rd_ptr`−1 in one cycle: both take effect with no lost cycle.
- Wrap-around: pointers wrap modulo 2·`MAX_OUTSTANDING`. Full is distinguished from empty by the wrap bit.

## Timing
- Request accepted in cycle N → `afu_tx_rd_valid` = 1 with its header in cycle N+1 only.
- With no accepted request, `afu_tx_rd_valid` = 0.
- `spl_tx_rd_almostfull` high in cycle N → no request is accepted in cycle N. An issue registered from cycle N−1 still appears in cycle N; the almost-full slack absorbs it.
- Response in cycle M whose slot is at the head → `rsp_valid` = 1 in cycle M+2.
- `rsp_valid` may deassert only after a consume. `rsp_tag` and `rsp_data` are held stable while `rsp_valid` && !`rsp_ready`.
- Reset values (when `spl_reset_n` = 0 at a clock edge):
  - `afu_tx_rd_valid`, `rsp_valid` and `err_unexpected_rsp` are 0.
  - `outstanding` is 0; all pointers and per-slot bits are cleared.
  - `afu_tx_rd_hdr`, `rsp_tag` and `rsp_data` are 0.
- Reset mid-operation:
  - In-flight reads are abandoned.
  - A stale response arriving after reset finds no pending slot, so it is dropped and sets `err_unexpected_rsp`. The driver resets only when quiescent.
- `req_ready` is 0 during reset and in the first cycle after it; acceptance begins in the second cycle after reset deasserts.

## Test plan
- Single read: request with addr 0x1000, tag 0x0A5 accepted in cycle N. Expect `afu_tx_rd_valid` in N+1 with mdata 0 and address 0x1000. Respond with data 0xDEAD… in cycle M. Expect `rsp_valid` in M+2 with tag 0x0A5 and data 0xDEAD….
- Out-of-order return with `MAX_OUTSTANDING`=4: issue tags 1,2,3,4 and respond to slots 3,1,0,2. Expect delivery in order 1,2,3,4. Expect `req_ready` = 0 while `outstanding` = 4.
- Almost-full throttle: hold `spl_tx_rd_almostfull` high for 10 cycles with `req_valid` = 1. Expect 0 issues during that window and issue to resume one cycle after it drops.
- Backpressure and wrap: 600 random reads with random `rsp_ready` at 30% duty. Expect all tags delivered in order, no drops, and `outstanding` returning to 0 at the end.
- Unexpected response: send a response with mdata 5 while idle. Expect no `rsp_valid` and `err_unexpected_rsp` = 1 until reset.
- Reset mid-flight: reset with 3 reads outstanding. Expect all outputs at their reset values and `outstanding` = 0. A new read then completes normally.

Source files
------------

// File: rtl/afu_rd_issue.sv
// ---------------------------------------------------------------------------
// ccip_if_pkg: the subset of CCI-P C0 header types and encodings used by the
// read issue stage.
//
// afu_rd_issue: issues cache-line reads from the SMEM pipeline as CCI-P C0
// memory read headers and returns the lines to the pipeline in request order.
// Each accepted request takes one slot of a MAX_OUTSTANDING-entry ring. The
// slot index travels in mdata, so responses may come back in any order. They
// are written back by slot and drained from the ring head.
//
// Ports
//   CLK_400M, spl_reset_n        clock, synchronous active-low reset
//   req_valid/req_ready          request handshake (addr, tag)
//   spl_tx_rd_almostfull         C0 TX throttle
//   afu_tx_rd_valid/_hdr         registered C0 read request
//   spl_rx_rd_valid/_hdr, spl_rx_data   C0 read response (cannot be stalled)
//   rsp_valid/rsp_ready          ordered response handshake (tag, data)
//   outstanding                  occupied ring slots
//   err_unexpected_rsp           sticky: response for a slot not awaiting data
//
// Handshakes: a transfer happens on a rising edge where valid && ready. A
// valid output, once raised, stays high with its payload held until the
// transfer happens. ready never depends on the valid of the same channel.
// ---------------------------------------------------------------------------
package ccip_if_pkg;
  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;
endpackage

module afu_rd_issue
  import ccip_if_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int TAG_W           = 16
) (
  input  logic                              CLK_400M,
  input  logic                              spl_reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [41:0]                       req_addr,
  input  logic [TAG_W-1:0]                  req_tag,
  input  logic                              spl_tx_rd_almostfull,
  output logic                              afu_tx_rd_valid,
  output t_ccip_c0_ReqMemHdr                afu_tx_rd_hdr,
  input  logic                              spl_rx_rd_valid,
  input  t_ccip_c0_RspMemHdr                spl_rx_rd_hdr,
  input  logic [511:0]                      spl_rx_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [TAG_W-1:0]                  rsp_tag,
  output logic [511:0]                      rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_unexpected_rsp
);

  localparam int IW = $clog2(MAX_OUTSTANDING);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_OUTSTANDING);

  // Ring pointers carry one extra wrap bit so full and empty differ.
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] pending_q, pending_d;
  logic [MAX_OUTSTANDING-1:0] filled_q, filled_d;
  logic                       ready_en_q;

  logic                       tx_valid_q, tx_valid_d;
  t_ccip_c0_ReqMemHdr         tx_hdr_q, tx_hdr_d;

  logic                       rx_valid_q;
  logic [IW-1:0]              rx_slot_q;
  logic [511:0]               rx_data_q;

  logic                       rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]           rsp_tag_q, rsp_tag_d;
  logic [511:0]               rsp_data_q, rsp_data_d;
  logic                       err_q, err_d;

  logic [TAG_W-1:0]           tag_mem  [MAX_OUTSTANDING];
  logic [511:0]               data_mem [MAX_OUTSTANDING];

  logic [PW-1:0]              occ;
  logic                       full;
  logic                       accept;
  logic [IW-1:0]              wr_idx;
  logic [IW-1:0]              rd_idx;
  logic                       rx_ok;
  logic                       consume;
  logic [PW-1:0]              next_rd_ptr;
  logic [IW-1:0]              cand_idx;
  logic                       cand_hit;
  logic                       load;
  t_ccip_c0_ReqMemHdr         hdr_new;

  // Only the slot bits of mdata matter here; the rest of the response
  // header is intentionally ignored.
  logic                       unused_rx_hdr;
  assign unused_rx_hdr = ^spl_rx_rd_hdr;

  assign occ     = wr_ptr_q - rd_ptr_q;
  assign full    = (occ == MAX_CNT);
  assign wr_idx  = wr_ptr_q[IW-1:0];
  assign rd_idx  = rd_ptr_q[IW-1:0];

  // ready_en_q keeps ready low for the first cycle after reset releases.
  assign req_ready = spl_reset_n && ready_en_q && !spl_tx_rd_almostfull && !full;
  assign accept    = req_valid && req_ready;

  // A response is only legal for a slot that is issued and not yet filled.
  assign rx_ok   = rx_valid_q && pending_q[rx_slot_q] && !filled_q[rx_slot_q];
  assign consume = rsp_valid_q && rsp_ready;

  // Slot that will sit at the ring head after this edge. Its line may be
  // arriving right now, so the output load bypasses the data array in that case.
  assign next_rd_ptr = consume ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
  assign cand_idx    = next_rd_ptr[IW-1:0];
  assign cand_hit    = rx_ok && (rx_slot_q == cand_idx);
  assign load        = (!rsp_valid_q || consume) && (filled_q[cand_idx] || cand_hit);

  always_comb begin
    hdr_new          = '0;
    hdr_new.vc_sel   = eVC_VA;
    hdr_new.cl_len   = eCL_LEN_1;
    hdr_new.req_type = eREQ_RDLINE_I;
    hdr_new.address  = req_addr;
    hdr_new.mdata    = 16'(wr_idx);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = next_rd_ptr;
    pending_d   = pending_q;
    filled_d    = filled_q;
    tx_valid_d  = accept;
    tx_hdr_d    = tx_hdr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;

    if (accept) begin
      wr_ptr_d          = wr_ptr_q + PW'(1);
      pending_d[wr_idx] = 1'b1;
      tx_hdr_d          = hdr_new;
    end

    // Clear the delivered slot before setting new fills; the two never name
    // the same slot because the head slot is already filled when consumed.
    if (consume) begin
      pending_d[rd_idx] = 1'b0;
      filled_d[rd_idx]  = 1'b0;
      rsp_valid_d       = 1'b0;
    end

    if (rx_ok) begin
      filled_d[rx_slot_q] = 1'b1;
    end else if (rx_valid_q) begin
      err_d = 1'b1;
    end

    if (load) begin
      rsp_valid_d = 1'b1;
      rsp_tag_d   = tag_mem[cand_idx];
      rsp_data_d  = cand_hit ? rx_data_q : data_mem[cand_idx];
    end
  end

  always_ff @(posedge CLK_400M) begin
    if (!spl_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      filled_q    <= '0;
      ready_en_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_hdr_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_slot_q   <= '0;
      rx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      filled_q    <= filled_d;
      ready_en_q  <= 1'b1;
      tx_valid_q  <= tx_valid_d;
      tx_hdr_q    <= tx_hdr_d;
      rx_valid_q  <= spl_rx_rd_valid;
      rx_slot_q   <= spl_rx_rd_hdr.mdata[IW-1:0];
      rx_data_q   <= spl_rx_data;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Storage arrays need no reset: a slot is read only after its valid bits
  // have been set by a write.
  always_ff @(posedge CLK_400M) begin
    if (accept) begin
      tag_mem[wr_idx] <= req_tag;
    end
    if (rx_ok) begin
      data_mem[rx_slot_q] <= rx_data_q;
    end
  end

  assign afu_tx_rd_valid    = tx_valid_q;
  assign afu_tx_rd_hdr      = tx_hdr_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_tag            = rsp_tag_q;
  assign rsp_data           = rsp_data_q;
  assign outstanding        = occ;
  assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_afu_rd_issue.sv
// Bench for afu_rd_issue with a 4-slot ring. The reference model tracks the
// accepted and delivered counts, a scoreboard of (tag, data) in request order,
// and the set of issued-but-unanswered slots. Slot k of the run after reset is
// k mod 4.
module tb_afu_rd_issue;
  import ccip_if_pkg::*;

  localparam int MAXO  = 4;
  localparam int TAG_W = 16;
  localparam int PW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [41:0]         req_addr;
  logic [TAG_W-1:0]    req_tag;
  logic                af;
  logic                tx_valid;
  t_ccip_c0_ReqMemHdr  tx_hdr;
  logic                rx_valid;
  t_ccip_c0_RspMemHdr  rx_hdr;
  logic [511:0]        rx_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [TAG_W-1:0]    rsp_tag;
  logic [511:0]        rsp_data;
  logic [PW-1:0]       outstanding;
  logic                err;

  afu_rd_issue #(.MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)) dut (
    .CLK_400M             (clk),
    .spl_reset_n          (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_tag              (req_tag),
    .spl_tx_rd_almostfull (af),
    .afu_tx_rd_valid      (tx_valid),
    .afu_tx_rd_hdr        (tx_hdr),
    .spl_rx_rd_valid      (rx_valid),
    .spl_rx_rd_hdr        (rx_hdr),
    .spl_rx_data          (rx_data),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_tag              (rsp_tag),
    .rsp_data             (rsp_data),
    .outstanding          (outstanding),
    .err_unexpected_rsp   (err)
  );

  // ---------------- scoreboard / model state ----------------
  logic [TAG_W+511:0] exp_q[$];
  int                 aw_slot[$];
  logic [511:0]       aw_data[$];
  logic [511:0]       req_line;

  int                 total = 0;
  int                 bad   = 0;
  int                 acc_cnt, con_cnt, since_rst;
  logic               prev_acc, prev_hold, err_exp, err_stage, rx_unexp;
  t_ccip_c0_ReqMemHdr exp_hdr;
  logic [511:0]       prev_data;

  task automatic chk(input string name, input logic [575:0] obs, input logic [575:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic respond_slot(input int slot);
    int idx;
    idx = -1;
    for (int i = 0; i < aw_slot.size(); i++)
      if (idx < 0 && aw_slot[i] == (slot % MAXO)) idx = i;
    rx_hdr           = '0;
    rx_hdr.resp_type = eRSP_RDLINE;
    rx_hdr.mdata     = 16'(slot);
    rx_valid         = 1'b1;
    if (idx >= 0) begin
      rx_data  = aw_data[idx];
      rx_unexp = 1'b0;
      aw_slot.delete(idx);
      aw_data.delete(idx);
    end else begin
      rx_data  = rand_line();
      rx_unexp = 1'b1;
    end
  endtask

  // One clock cycle: called at posedge+1 after the inputs are driven. Checks
  // outputs against the model, updates the model, and returns at the next posedge+1.
  task automatic cycle();
    logic model_ready, acc_now, stage_n;
    #1;
    model_ready = rst_n && (since_rst >= 1) && !af && ((acc_cnt - con_cnt) < MAXO);
    chk("req_ready", req_ready, model_ready);
    chk("outstanding", outstanding, acc_cnt - con_cnt);
    chk("tx_valid", tx_valid, prev_acc);
    chk("err_sticky", err, err_exp);
    if (prev_hold) chk("rsp_hold", rsp_valid, 1'b1);
    if (prev_acc) begin
      chk("tx_hdr", tx_hdr, exp_hdr);
      aw_slot.push_back(int'(exp_hdr.mdata));
      aw_data.push_back(prev_data);
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_spurious", rsp_valid, 1'b0);
      else begin
        chk("rsp_tag", rsp_tag, exp_q[0][TAG_W+511:512]);
        chk("rsp_data", rsp_data, exp_q[0][511:0]);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          con_cnt++;
        end
      end
    end
    acc_now = req_valid && model_ready;
    if (acc_now) begin
      exp_q.push_back({req_tag, req_line});
      exp_hdr          = '0;
      exp_hdr.vc_sel   = eVC_VA;
      exp_hdr.cl_len   = eCL_LEN_1;
      exp_hdr.req_type = eREQ_RDLINE_I;
      exp_hdr.address  = req_addr;
      exp_hdr.mdata    = 16'(acc_cnt % MAXO);
      prev_data        = req_line;
      acc_cnt++;
    end
    stage_n   = rx_valid && rx_unexp && rst_n;
    prev_hold = rsp_valid && !rsp_ready && rst_n;
    @(posedge clk);
    prev_acc  = acc_now;
    err_exp   = err_exp | err_stage;
    err_stage = stage_n;
    if (!rst_n) begin
      acc_cnt = 0; con_cnt = 0; since_rst = 0;
      exp_q.delete(); aw_slot.delete(); aw_data.delete();
      prev_acc = 0; prev_hold = 0; err_exp = 0; err_stage = 0;
    end else begin
      since_rst++;
    end
    #1;
    rx_valid = 1'b0;
    rx_unexp = 1'b0;
  endtask

  task automatic issue(input logic [TAG_W-1:0] tag, input logic [41:0] addr, input logic [511:0] line);
    req_valid = 1'b1;
    req_tag   = tag;
    req_addr  = addr;
    req_line  = line;
  endtask

  task automatic drain(input string name);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && !(exp_q.size() == 0 && aw_slot.size() == 0 && !prev_acc); i++) begin
      if (aw_slot.size() > 0) respond_slot(aw_slot[0]);
      cycle();
    end
    cycle();
    chk({name, "_drain_sb"}, exp_q.size(), 0);
    chk({name, "_drain_outstanding"}, outstanding, 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tx_valid"}, tx_valid, 1'b0);
    chk({name, "_tx_hdr"}, tx_hdr, 0);
    chk({name, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({name, "_rsp_tag"}, rsp_tag, 0);
    chk({name, "_rsp_data"}, rsp_data, 0);
    chk({name, "_err"}, err, 1'b0);
    chk({name, "_outstanding"}, outstanding, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int win_issues, base_acc, base_con;
    logic [TAG_W-1:0] t;
    int ooo_slots [4];
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; req_line = '0;
    af = 1'b0; rx_valid = 1'b0; rx_hdr = '0; rx_data = '0; rsp_ready = 1'b0;
    acc_cnt = 0; con_cnt = 0; since_rst = 0; prev_acc = 0; prev_hold = 0;
    err_exp = 0; err_stage = 0; rx_unexp = 0; exp_hdr = '0; prev_data = '0;

    @(posedge clk); #1;
    cycle();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    cycle();                       // first cycle after release: not ready
    cycle();                       // second cycle: ready

    // Single read
    issue(16'h00A5, 42'h1000, {16{32'hDEADBEEF}});
    cycle();
    req_valid = 1'b0;
    cycle();                       // header shows address 0x1000, mdata 0
    respond_slot(0);
    cycle();                       // cycle M
    chk("single_m1_rsp_valid", rsp_valid, 1'b0);
    cycle();
    chk("single_m2_rsp_valid", rsp_valid, 1'b1);
    chk("single_m2_rsp_tag", rsp_tag, 16'h00A5);
    rsp_ready = 1'b1;
    cycle();
    drain("single");

    // Out-of-order return: tags 1..4 land in slots 1,2,3,0
    rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      t = TAG_W'(i);
      issue(t, 42'h2000 + 42'(i), {16{24'hC0FFEE, 8'(i)}});
      cycle();
    end
    issue(16'h0005, 42'h2005, rand_line());
    cycle();
    chk("ooo_full_outstanding", outstanding, 4);
    chk("ooo_full_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    ooo_slots = '{3, 1, 0, 2};
    for (int i = 0; i < 4; i++) begin
      respond_slot(ooo_slots[i]);
      cycle();
    end
    drain("ooo");

    // Almost-full throttle
    af = 1'b1;
    issue(16'h0077, 42'h3000, rand_line());
    win_issues = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      win_issues += int'(tx_valid);
    end
    chk("af_window_issues", win_issues, 0);
    af = 1'b0;
    cycle();
    req_valid = 1'b0;
    chk("af_resume_tx", tx_valid, 1'b1);
    drain("af");

    // Random traffic with backpressure and pointer wrap
    base_acc = acc_cnt;
    base_con = con_cnt;
    for (int c = 0; c < 20000 && ((acc_cnt - base_acc) < 600 || exp_q.size() > 0 || prev_acc); c++) begin
      if ((acc_cnt - base_acc) < 600 && $urandom_range(0, 3) != 0)
        issue(TAG_W'($urandom), 42'({$urandom_range(0, 1023), $urandom}), rand_line());
      else
        req_valid = 1'b0;
      af        = ($urandom_range(0, 9) < 2);
      rsp_ready = ($urandom_range(0, 9) < 3);
      if (aw_slot.size() > 0 && $urandom_range(0, 1) == 1)
        respond_slot(aw_slot[$urandom_range(0, aw_slot.size() - 1)]);
      cycle();
    end
    req_valid = 1'b0;
    af = 1'b0;
    cycle();
    chk("rand_delivered", con_cnt - base_con, 600);
    chk("rand_outstanding", outstanding, 0);
    chk("rand_no_err", err, 1'b0);

    // Unexpected response while idle
    respond_slot(5);
    cycle();
    cycle();
    cycle();
    chk("unexp_err", err, 1'b1);
    chk("unexp_no_rsp", rsp_valid, 1'b0);
    cycle();
    chk("unexp_err_held", err, 1'b1);

    // Reset with three reads in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(16'h0031 + TAG_W'(i), 42'h4000 + 42'(i), rand_line());
      cycle();
    end
    req_valid = 1'b0;
    cycle();
    chk("midrst_outstanding", outstanding, 3);
    rst_n = 1'b0;
    cycle();
    chk_reset_outputs("midrst");
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    respond_slot(1);               // stale response from before reset
    cycle();
    cycle();
    cycle();
    chk("stale_err", err, 1'b1);
    issue(16'h0044, 42'h5000, rand_line());
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("post_rst_mdata", tx_hdr.mdata, 0);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
